// File: rtl/program_loader_pkg.sv
// Shared types and sizes for the boot-time program loader.
package program_loader_pkg;

    localparam int unsigned WORD_SIZE = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned BYTE_W    = 8;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_LEN  = 3'd1,
        LDR_ADDR = 3'd2,
        LDR_DATA = 3'd3,
        LDR_SUM  = 3'd4,
        LDR_ERR  = 3'd5
    } ldr_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [WORD_SIZE-1:0] data;
    } ram_wr_t;

    // States in which a frame is being received and bytes are accepted.
    function automatic logic frame_active(input ldr_state_e s);
        return (s == LDR_LEN) || (s == LDR_ADDR) || (s == LDR_DATA) || (s == LDR_SUM);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream and RAM write port of the program loader.
interface program_loader_if;
    import program_loader_pkg::*;

    logic                 in_valid;
    logic [BYTE_W-1:0]    in_data;
    logic                 in_ready;
    logic                 ram_wren;
    logic [ADDR_W-1:0]    ram_addr;
    logic [WORD_SIZE-1:0] ram_data;

    modport master (
        input  in_valid, in_data,
        output in_ready, ram_wren, ram_addr, ram_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, ram_wren, ram_addr, ram_data
    );
endinterface

// File: rtl/program_loader.sv
// Receives a framed program image (length, address, payload, checksum) and writes
// it to RAM, holding the CPU in reset until a load completes with a good checksum.
module program_loader
    import program_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    program_loader_if.master        bus,
    output logic                    cpu_rst,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    ldr_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [BYTE_W-1:0]   sum_q, sum_d;
    logic [BYTE_W-1:0]   rem_q, rem_d;
    ram_wr_t             wr_q, wr_d;
    logic                wren_q, wren_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                accept;

    assign accept = bus.in_valid & in_ready_q;

    // Frame sequencing, checksum accumulation and RAM write generation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sum_d     = sum_q;
        rem_d     = rem_q;
        wr_d      = wr_q;
        wren_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        cpu_rst_d = cpu_rst_q;

        case (state_q)
            LDR_IDLE, LDR_ERR: begin
                if (start) begin
                    state_d   = LDR_LEN;
                    err_d     = 1'b0;
                    sum_d     = '0;
                    cpu_rst_d = 1'b1;
                end
            end
            LDR_LEN: begin
                if (accept) begin
                    rem_d   = bus.in_data;
                    state_d = LDR_ADDR;
                end
            end
            LDR_ADDR: begin
                if (accept) begin
                    ptr_d   = ADDR_W'(bus.in_data);
                    state_d = LDR_DATA;
                end
            end
            LDR_DATA: begin
                if (accept) begin
                    wren_d       = 1'b1;
                    wr_d.addr    = ptr_q;
                    wr_d.data    = WORD_SIZE'(bus.in_data);
                    ptr_d        = ptr_q + ADDR_W'(1);
                    sum_d        = sum_q + bus.in_data;
                    // A stored length of 0 wraps to 255 here, giving 256 payload bytes.
                    rem_d        = rem_q - BYTE_W'(1);
                    if (rem_q == BYTE_W'(1)) begin
                        state_d = LDR_SUM;
                    end
                end
            end
            LDR_SUM: begin
                if (accept) begin
                    if (bus.in_data == sum_q) begin
                        state_d   = LDR_IDLE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d   = LDR_ERR;
                        err_d     = 1'b1;
                    end
                end
            end
            default: state_d = LDR_IDLE;
        endcase

        in_ready_d = frame_active(state_d);
        busy_d     = frame_active(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LDR_IDLE;
            ptr_q      <= '0;
            sum_q      <= '0;
            rem_q      <= '0;
            wr_q       <= '0;
            wren_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sum_q      <= sum_d;
            rem_q      <= rem_d;
            wr_q       <= wr_d;
            wren_q     <= wren_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_rst_q  <= cpu_rst_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ram_wren = wren_q;
    assign bus.ram_addr = wr_q.addr;
    assign bus.ram_data = wr_q.data;
    assign cpu_rst      = cpu_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
